// File: rtl/scroll_tile_engine_if.sv
// Bus bundle for the scrolling tile engine.
// Groups the pixel stream, the CPU config port, the map RAM port, the pattern ROM
// port and the pixel output. The master side is the surrounding system: it supplies
// x/y/config and plays the map RAM and pattern ROM.
interface scroll_tile_engine_if #(
  parameter int MAP_AW = 13
);
  logic              video_on;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              cfg_we;
  logic [1:0]        cfg_sel;
  logic [9:0]        cfg_wdata;
  logic [MAP_AW-1:0] map_addr;
  logic [7:0]        map_data;
  logic [6:0]        pat_x;
  logic [5:0]        pat_y;
  logic [11:0]       pat_data;
  logic              pixel_on;
  logic [11:0]       color;

  modport master (
    output video_on, x, y, cfg_we, cfg_sel, cfg_wdata, map_data, pat_data,
    input  map_addr, pat_x, pat_y, pixel_on, color
  );

  modport slave (
    input  video_on, x, y, cfg_we, cfg_sel, cfg_wdata, map_data, pat_data,
    output map_addr, pat_x, pat_y, pixel_on, color
  );
endinterface

// File: rtl/scroll_tile_engine.sv
// Pipelined tile-map background renderer with hardware scrolling.
// Screen (x,y) plus the active scroll offset gives a world coordinate, which picks a
// tile from map RAM; the tile index plus the in-tile offset picks a texel from the
// pattern ROM. Output is 3 clocks behind the input pixel. Scroll/ctrl writes land in
// a shadow copy and only become active at the start of line SCREEN_H.
module scroll_tile_engine #(
  parameter int          TILE_W      = 8,
  parameter int          TILE_H      = 8,
  parameter int          MAP_COLS    = 128,
  parameter int          MAP_ROWS    = 64,
  parameter int          SCREEN_H    = 480,
  parameter logic [11:0] TRANSPARENT = 12'h00f,
  parameter int          MAP_AW      = 13
) (
  input logic                  clk,
  input logic                  reset,
  scroll_tile_engine_if.slave  bus
);

  localparam int TXB = $clog2(TILE_W);
  localparam int TYB = $clog2(TILE_H);
  localparam int WXB = TXB + $clog2(MAP_COLS);
  localparam int WYB = TYB + $clog2(MAP_ROWS);
  localparam logic [10:0] WORLD_W = 11'(MAP_COLS * TILE_W);
  localparam logic [10:0] WORLD_H = 11'(MAP_ROWS * TILE_H);

  // Shadow (CPU-written) and active (frame-stable) configuration
  logic [9:0] sh_sx, sh_sy, act_sx, act_sy;
  logic [1:0] sh_ctrl, act_ctrl;

  // S0 -> S1 stage
  logic [TXB-1:0] fx_q;
  logic [TYB-1:0] fy_q;
  logic           s0_valid, s0_oom, s0_en;

  // S1 -> S2 stage
  logic s1_valid, s1_ok;

  logic           frame_edge;
  logic [10:0]    wx_sum, wy_sum;
  logic           oom;
  logic           opaque;
  logic [TXB+3:0] pat_x_full;
  logic [TYB+3:0] pat_y_full;

  // World coordinates are formed one bit wider than the world so overflow is visible
  assign frame_edge = (bus.x == 10'd0) && (bus.y == 10'(SCREEN_H));
  assign wx_sum     = {1'b0, bus.x} + {1'b0, act_sx};
  assign wy_sum     = {1'b0, bus.y} + {1'b0, act_sy};
  assign oom        = ~act_ctrl[1] & ((wx_sum >= WORLD_W) | (wy_sum >= WORLD_H));
  assign pat_x_full = {bus.map_data[3:0], fx_q};
  assign pat_y_full = {bus.map_data[7:4], fy_q};
  assign opaque     = s1_valid & s1_ok & (bus.pat_data != TRANSPARENT);

  // CPU writes go to the shadow set; the active set copies the pre-write shadow at the frame edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_sx    <= '0;
      sh_sy    <= '0;
      sh_ctrl  <= 2'b11;
      act_sx   <= '0;
      act_sy   <= '0;
      act_ctrl <= 2'b11;
    end else begin
      if (bus.cfg_we) begin
        case (bus.cfg_sel)
          2'd0:    sh_sx   <= bus.cfg_wdata;
          2'd1:    sh_sy   <= bus.cfg_wdata;
          2'd2:    sh_ctrl <= bus.cfg_wdata[1:0];
          default: ;
        endcase
      end
      if (frame_edge) begin
        act_sx   <= sh_sx;
        act_sy   <= sh_sy;
        act_ctrl <= sh_ctrl;
      end
    end
  end

  // S0: wrapped world coordinate -> map address, keep in-tile offset and qualifiers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.map_addr <= '0;
      fx_q         <= '0;
      fy_q         <= '0;
      s0_valid     <= 1'b0;
      s0_oom       <= 1'b0;
      s0_en        <= 1'b0;
    end else begin
      bus.map_addr <= MAP_AW'({wy_sum[WYB-1:TYB], wx_sum[WXB-1:TXB]});
      fx_q         <= wx_sum[TXB-1:0];
      fy_q         <= wy_sum[TYB-1:0];
      s0_valid     <= bus.video_on;
      s0_oom       <= oom;
      s0_en        <= act_ctrl[0];
    end
  end

  // S1: tile index plus in-tile offset -> pattern ROM address (silently truncated)
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pat_x <= '0;
      bus.pat_y <= '0;
      s1_valid  <= 1'b0;
      s1_ok     <= 1'b0;
    end else begin
      bus.pat_x <= 7'(pat_x_full);
      bus.pat_y <= 6'(pat_y_full);
      s1_valid  <= s0_valid;
      s1_ok     <= ~s0_oom & s0_en;
    end
  end

  // S2: texel arrives; register the final pixel with transparency applied
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pixel_on <= 1'b0;
      bus.color    <= '0;
    end else begin
      bus.pixel_on <= opaque;
      bus.color    <= opaque ? bus.pat_data : 12'd0;
    end
  end

endmodule

// File: tb/tb_scroll_tile_engine.sv
// Scoreboard bench for scroll_tile_engine.
// The bench plays map RAM and pattern ROM, keeps its own model of the shadow/active
// scroll registers, and queues the expected map address, pattern address and pixel
// for every driven pixel with the clock at which each should appear.
module tb_scroll_tile_engine;

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  scroll_tile_engine_if #(.MAP_AW(13)) bus();

  logic [7:0]  map_mem [0:8191];
  logic [11:0] pat_mem [0:63][0:127];

  exp_t addr_q[$];
  exp_t pat_q[$];
  exp_t out_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         m_sh_sx, m_sh_sy, m_act_sx, m_act_sy;
  logic [1:0] m_sh_ctrl, m_act_ctrl;

  // Free-running pixel clock
  always #5 clk = ~clk;

  assign bus.map_data = map_mem[bus.map_addr];
  assign bus.pat_data = pat_mem[bus.pat_y][bus.pat_x];

  scroll_tile_engine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got=%0h want=%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic checkDue();
    exp_t e;
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      e = addr_q.pop_front();
      checkOutput("map_addr", 32'(bus.map_addr), e.a);
    end
    while (pat_q.size() > 0 && pat_q[0].due <= cyc) begin
      e = pat_q.pop_front();
      checkOutput("pat_x", 32'(bus.pat_x), e.a);
      checkOutput("pat_y", 32'(bus.pat_y), e.b);
    end
    while (out_q.size() > 0 && out_q[0].due <= cyc) begin
      e = out_q.pop_front();
      checkOutput("pixel_on", 32'(bus.pixel_on), e.a);
      checkOutput("color", 32'(bus.color), e.b);
    end
  endtask

  // Drive one pixel clock of inputs, predict its results, then check whatever is due
  task automatic applyStimulus(input int px, input int py, input logic vo, input logic we,
                               input logic [1:0] sel, input logic [9:0] wd, input logic rst);
    int wx, wy, wxm, wym, addr, pxe, pye;
    logic [7:0] md;
    logic [11:0] tex;
    logic oom, on;
    @(negedge clk);
    bus.x         = px[9:0];
    bus.y         = py[9:0];
    bus.video_on  = vo;
    bus.cfg_we    = we;
    bus.cfg_sel   = sel;
    bus.cfg_wdata = wd;
    reset         = rst;
    if (rst) begin
      addr_q.delete();
      pat_q.delete();
      out_q.delete();
      addr_q.push_back('{cyc + 1, 32'd0, 32'd0});
      pat_q.push_back('{cyc + 1, 32'd0, 32'd0});
      for (int k = 1; k <= 3; k++) out_q.push_back('{cyc + k, 32'd0, 32'd0});
      m_sh_sx = 0; m_sh_sy = 0; m_act_sx = 0; m_act_sy = 0;
      m_sh_ctrl = 2'b11; m_act_ctrl = 2'b11;
    end else begin
      wx  = px + m_act_sx;
      wy  = py + m_act_sy;
      oom = !m_act_ctrl[1] && (wx >= 1024 || wy >= 512);
      wxm = wx % 1024;
      wym = wy % 512;
      addr = (wym / 8) * 128 + wxm / 8;
      md  = map_mem[addr];
      pxe = (int'(md[3:0]) * 8 + wxm % 8) % 128;
      pye = (int'(md[7:4]) * 8 + wym % 8) % 64;
      tex = pat_mem[pye][pxe];
      on  = vo && !oom && m_act_ctrl[0] && (tex != 12'h00f);
      addr_q.push_back('{cyc + 1, 32'(addr), 32'd0});
      pat_q.push_back('{cyc + 2, 32'(pxe), 32'(pye)});
      out_q.push_back('{cyc + 3, 32'(on), on ? 32'(tex) : 32'd0});
      if (px == 0 && py == 480) begin
        m_act_sx = m_sh_sx; m_act_sy = m_sh_sy; m_act_ctrl = m_sh_ctrl;
      end
      if (we) begin
        case (sel)
          2'd0: m_sh_sx = int'(wd);
          2'd1: m_sh_sy = int'(wd);
          2'd2: m_sh_ctrl = wd[1:0];
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    checkDue();
  endtask

  task automatic pix(input int px, input int py);
    applyStimulus(px, py, 1'b1, 1'b0, 2'd0, 10'd0, 1'b0);
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [9:0] wd);
    applyStimulus(5, 490, 1'b0, 1'b1, sel, wd, 1'b0);
  endtask

  task automatic frameEdge();
    applyStimulus(0, 480, 1'b0, 1'b0, 2'd0, 10'd0, 1'b0);
  endtask

  // Let every outstanding expectation retire without queueing new ones
  task automatic drain();
    @(negedge clk);
    bus.video_on = 1'b0;
    bus.cfg_we   = 1'b0;
    bus.x        = 10'd5;
    bus.y        = 10'd490;
    repeat (3) begin
      @(posedge clk);
      #1;
      cyc++;
      checkDue();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.video_on = 1'b0; bus.x = '0; bus.y = '0;
    bus.cfg_we = 1'b0; bus.cfg_sel = '0; bus.cfg_wdata = '0;
    for (int i = 0; i < 8192; i++) map_mem[i] = 8'h21;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++) pat_mem[r][c] = 12'(r * 64 + c + 32);
    pat_mem[21][13] = 12'h0f0;

    // Reset, then the basic lookup: x=13,y=5 -> addr 1, pat (13,21), colour 0f0
    applyStimulus(0, 0, 1'b0, 1'b0, 2'd0, 10'd0, 1'b1);
    pix(13, 5);
    for (int i = 0; i < 20; i++) pix(i, 5 + i % 3);
    drain();

    // Transparent texel at the same spot
    pat_mem[21][13] = 12'h00f;
    pix(13, 5);
    pix(12, 5);
    applyStimulus(13, 5, 1'b0, 1'b0, 2'd0, 10'd0, 1'b0);
    drain();

    for (int i = 0; i < 8192; i++) map_mem[i] = 8'(i * 37 + 5);

    // Scroll write mid-frame is deferred to the frame edge; simultaneous write waits a frame
    applyStimulus(50, 100, 1'b1, 1'b1, 2'd0, 10'd4, 1'b0);
    pix(51, 100);
    pix(0, 101);
    applyStimulus(1, 480, 1'b0, 1'b0, 2'd0, 10'd0, 1'b0);
    frameEdge();
    pix(0, 0);
    pix(1, 0);
    cfgWrite(2'd0, 10'd6);
    applyStimulus(0, 480, 1'b0, 1'b1, 2'd0, 10'd8, 1'b0);
    pix(0, 0);
    frameEdge();
    pix(0, 0);

    // Wrapping in x and y, then the same with wrap disabled
    cfgWrite(2'd0, 10'd1020);
    frameEdge();
    pix(10, 3);
    pix(3, 3);
    cfgWrite(2'd1, 10'd500);
    frameEdge();
    pix(10, 20);
    pix(10, 5);
    cfgWrite(2'd2, 10'd1);
    frameEdge();
    pix(10, 20);
    pix(2, 2);
    cfgWrite(2'd0, 10'd0);
    cfgWrite(2'd1, 10'd0);
    cfgWrite(2'd3, 10'd0);
    frameEdge();
    pix(100, 100);
    pix(30, 600);

    // Enable off for a frame, then video_on low
    cfgWrite(2'd2, 10'd2);
    pix(40, 40);
    frameEdge();
    for (int i = 0; i < 6; i++) pix(40 + i, 40);
    cfgWrite(2'd2, 10'd3);
    frameEdge();
    for (int i = 0; i < 4; i++) applyStimulus(60 + i, 70, 1'b0, 1'b0, 2'd0, 10'd0, 1'b0);
    pix(64, 70);

    // Mid-line reset returns scroll and ctrl to defaults
    cfgWrite(2'd0, 10'd77);
    cfgWrite(2'd2, 10'd1);
    frameEdge();
    pix(20, 60);
    pix(21, 60);
    applyStimulus(22, 60, 1'b1, 1'b0, 2'd0, 10'd0, 1'b1);
    for (int i = 0; i < 5; i++) pix(23 + i, 60);
    pix(30, 600);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
